seg_pattern_decoder: RTL and testbench
======================================

Name: seg_pattern_decoder

Overview:
- Decodes a 7-bit active-low seven-segment pattern back into a 4-bit BCD digit; the inverse of the team's digit-to-segment encoder.
- Sampled patterns are filtered so that one is reported only after it is stable for STABLE_CYCLES accepted samples.
- Reports each new stable pattern once, as a one-cycle pulse: digit, blank or error.
- Used as a loopback checker on display drive lines and to read back segment buses from external boards.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical accepted samples required before a pattern is reported; legal range 1..255.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- seg_in  in  7  active-low segments; bit0=a, bit1=b … bit6=g.
- seg_vld  in  1  sample enable; seg_in is accepted only on edges where seg_vld=1.
- digit_out  out  4  last successfully decoded digit, held between reports.
- digit_valid  out  1  one-cycle pulse when a new digit is reported.
- pattern_err  out  1  one-cycle pulse when a new stable pattern is not in the decode table.
- blank  out  1  level; high while the last reported pattern is all-off (7'h7F).
- locked  out  1  level; high while in LOCKED.
- err_count  out  CNT_W  count of pattern_err pulses; saturates at 2^CNT_W-1.

Behaviour:
- Reset values (synchronous): every output is 0; the internal candidate is 0 and the stability count is 0; state goes to IDLE. Reset has priority over seg_vld.
- Decode table (seg_in -> digit):
  - 7'h40->0, 7'h79->1, 7'h24->2, 7'h30->3, 7'h19->4
  - 7'h12->5, 7'h02->6, 7'h78->7, 7'h00->8, 7'h10->9
  - 7'h7F is blank.
  - Every other value is an error.
- Stability filter, on each edge with seg_vld=1:
  - If seg_in differs from the candidate: the candidate loads seg_in and the count is set to 1.
  - Otherwise the count increments, saturating at STABLE_CYCLES.
  - Edges with seg_vld=0 change nothing; gaps do not break stability.
- Report condition: the sample that makes the count equal STABLE_CYCLES, with state IDLE or SETTLE.
  - Its decode result is registered on that same edge, so the output is visible in the following cycle.
  - Latency is STABLE_CYCLES accepted samples from the first sample of the pattern.
  - With STABLE_CYCLES=1, the first accepted sample reports.
- On report, exactly one of three outcomes:
  - Digit: digit_valid=1 for one cycle; digit_out updated; blank cleared.
  - Blank: blank set; no pulse; digit_out held.
  - Error: pattern_err=1 for one cycle; err_count increments (saturating); digit_out and blank held.
- State machine:
  - IDLE -> SETTLE on the first accepted sample. If STABLE_CYCLES=1, go directly to LOCKED with a report.
  - SETTLE -> LOCKED on report.
  - SETTLE -> SETTLE on a changed sample (count restarts at 1).
  - LOCKED -> SETTLE on an accepted sample differing from the candidate. It then reports again after STABLE_CYCLES samples, even if the pattern equals one reported earlier.
  - LOCKED with repeated identical samples: no further pulses.
  - locked=1 only in LOCKED.
- Pulse spacing: digit_valid and pattern_err are never high together. Consecutive pulses are at least STABLE_CYCLES accepted samples apart, and at least 2 cycles apart when STABLE_CYCLES=1.
- Reset mid-SETTLE discards the partial count. After reset, the same pattern is reported anew.

Optional Feature:
- Macro SEG_DECODE_HEX_ALPHA_EN.
- When defined, these patterns extend the table:
  - 7'h08->A(10), 7'h03->b(11), 7'h46->C(12)
  - 7'h21->d(13), 7'h06->E(14), 7'h0E->F(15)
  - They are reported via digit_valid.
- When undefined, these six patterns are errors.

Test Plan:
- rst, then seg_vld=1 with seg_in=7'h24 held for 4 cycles -> digit_valid pulses once, the cycle after the 4th sample; digit_out=2; locked=1; no further pulses while 7'h24 is held.
- seg_in sequence 7'h30,7'h30,7'h19,7'h19,7'h19,7'h19 -> no report for 3; a single report of digit 4 after the last sample.
- seg_vld toggled 1,0,1,0,1,0,1 with seg_in=7'h12 -> digit 5 reported after the 4th accepted sample (cycle 7).
- Stable 7'h55 -> pattern_err pulses once and err_count=1. Then 7'h7F stable -> blank=1, digit_out unchanged. Then 7'h00 stable -> digit_out=8, blank=0.
- CNT_W=2 with 5 distinct bad patterns, each stable -> err_count sticks at 3.
- 7'h08 stable -> digit_out=10 with SEG_DECODE_HEX_ALPHA_EN; pattern_err without. Separately, rst asserted after 2 samples of 7'h79 and then released with 7'h79 held -> report of digit 1 exactly 4 accepted samples after release.

Source files
------------

// File: rtl/seg_pattern_decoder.sv
// Purpose: decode a debounced active-low seven-segment pattern back to a BCD digit, blank or error.
// Latency: reports STABLE_CYCLES accepted samples after a pattern first appears; result is registered (+1 cycle).
// Backpressure: none; seg_vld only qualifies samples, idle cycles neither advance nor break the stability run.
// Optional: define SEG_DECODE_HEX_ALPHA_EN to also decode the hex letters A..F as digits 10..15.
module seg_pattern_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  input  logic             seg_vld,
  output logic [3:0]       digit_out,
  output logic             digit_valid,
  output logic             pattern_err,
  output logic             blank,
  output logic             locked,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;
  typedef enum logic [1:0] {K_DIGIT, K_BLANK, K_ERR} kind_t;

  localparam logic [7:0]       STABLE_N = 8'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t     state, state_nxt;
  kind_t      dec_kind;
  logic [3:0] dec_digit;
  logic [6:0] cand;
  logic [7:0] cnt, cnt_nxt;
  logic       differs;
  logic       report;

  // Pattern table lookup for the incoming sample.
  always_comb begin
    dec_kind  = K_ERR;
    dec_digit = 4'd0;
    case (seg_in)
      7'h40: begin dec_kind = K_DIGIT; dec_digit = 4'd0; end
      7'h79: begin dec_kind = K_DIGIT; dec_digit = 4'd1; end
      7'h24: begin dec_kind = K_DIGIT; dec_digit = 4'd2; end
      7'h30: begin dec_kind = K_DIGIT; dec_digit = 4'd3; end
      7'h19: begin dec_kind = K_DIGIT; dec_digit = 4'd4; end
      7'h12: begin dec_kind = K_DIGIT; dec_digit = 4'd5; end
      7'h02: begin dec_kind = K_DIGIT; dec_digit = 4'd6; end
      7'h78: begin dec_kind = K_DIGIT; dec_digit = 4'd7; end
      7'h00: begin dec_kind = K_DIGIT; dec_digit = 4'd8; end
      7'h10: begin dec_kind = K_DIGIT; dec_digit = 4'd9; end
`ifdef SEG_DECODE_HEX_ALPHA_EN
      7'h08: begin dec_kind = K_DIGIT; dec_digit = 4'd10; end
      7'h03: begin dec_kind = K_DIGIT; dec_digit = 4'd11; end
      7'h46: begin dec_kind = K_DIGIT; dec_digit = 4'd12; end
      7'h21: begin dec_kind = K_DIGIT; dec_digit = 4'd13; end
      7'h06: begin dec_kind = K_DIGIT; dec_digit = 4'd14; end
      7'h0E: begin dec_kind = K_DIGIT; dec_digit = 4'd15; end
`endif
      7'h7F: dec_kind = K_BLANK;
      default: dec_kind = K_ERR;
    endcase
  end

  // Stability filter: a changed sample restarts the run at 1, a repeat extends it up to STABLE_N.
  always_comb begin
    differs = (seg_in != cand);
    if (differs)
      cnt_nxt = 8'd1;
    else if (cnt == STABLE_N)
      cnt_nxt = cnt;
    else
      cnt_nxt = cnt + 8'd1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic; only accepted samples move the machine.
  always_comb begin
    state_nxt = state;
    if (seg_vld) begin
      case (state)
        IDLE:    state_nxt = report ? LOCKED : SETTLE;
        SETTLE:  if (report) state_nxt = LOCKED;
        LOCKED:  if (differs) state_nxt = SETTLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode: a report fires once per run, never while already locked.
  always_comb begin
    report = seg_vld && (state != LOCKED) && (cnt_nxt == STABLE_N);
    locked = (state == LOCKED);
  end

  // Candidate pattern and run length, advanced on accepted samples only.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand <= 7'h00;
      cnt  <= 8'd0;
    end else if (seg_vld) begin
      cand <= seg_in;
      cnt  <= cnt_nxt;
    end
  end

  // Registered report outputs: pulses last one cycle, digit and blank hold until the next report.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_out   <= 4'd0;
      digit_valid <= 1'b0;
      pattern_err <= 1'b0;
      blank       <= 1'b0;
      err_count   <= '0;
    end else begin
      digit_valid <= 1'b0;
      pattern_err <= 1'b0;
      if (report) begin
        case (dec_kind)
          K_DIGIT: begin
            digit_valid <= 1'b1;
            digit_out   <= dec_digit;
            blank       <= 1'b0;
          end
          K_BLANK: blank <= 1'b1;
          default: begin
            pattern_err <= 1'b1;
            if (err_count != CNT_MAX)
              err_count <= err_count + 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Bench for seg_pattern_decoder: run-length reference model checked every cycle,
// plus directed literal expectations; a second instance with CNT_W=2 checks counter saturation.
module tb_seg_pattern_decoder;

  localparam int STABLE = 4;
`ifdef SEG_DECODE_HEX_ALPHA_EN
  localparam int NGLYPH = 16;
`else
  localparam int NGLYPH = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       seg_vld;
  logic [6:0] seg_in;

  logic [3:0] d_digit;
  logic       d_dv, d_pe, d_blank, d_locked;
  logic [7:0] d_cnt;
  logic [3:0] e_digit;
  logic       e_dv, e_pe, e_blank, e_locked;
  logic [1:0] e_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // reference model state
  int         rl;
  logic [6:0] last;
  bit         rep_done;
  int         exp_digit, exp_dv, exp_pe, exp_blank, exp_locked, exp_cnt8, exp_cnt2;

  seg_pattern_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .seg_vld(seg_vld),
    .digit_out(d_digit), .digit_valid(d_dv), .pattern_err(d_pe),
    .blank(d_blank), .locked(d_locked), .err_count(d_cnt)
  );

  seg_pattern_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .seg_in(seg_in), .seg_vld(seg_vld),
    .digit_out(e_digit), .digit_valid(e_dv), .pattern_err(e_pe),
    .blank(e_blank), .locked(e_locked), .err_count(e_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Returns digit value, -1 for blank, -2 for an undecodable pattern.
  function automatic int model_decode(input logic [6:0] p);
    logic [6:0] g [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    if (p == 7'h7F) return -1;
    for (int i = 0; i < NGLYPH; i++)
      if (g[i] == p) return i;
    return -2;
  endfunction

  // Model: a run of identical accepted samples is reported once, when it reaches STABLE samples.
  always @(posedge clk) begin
    int r;
    if (rst) begin
      rl = 0; last = 7'h00; rep_done = 1'b0;
      exp_digit = 0; exp_dv = 0; exp_pe = 0; exp_blank = 0; exp_locked = 0;
      exp_cnt8 = 0; exp_cnt2 = 0;
    end else begin
      exp_dv = 0;
      exp_pe = 0;
      if (seg_vld) begin
        if (seg_in != last) begin
          last = seg_in; rl = 1; rep_done = 1'b0;
        end else begin
          rl++;
        end
        if (!rep_done && rl == STABLE) begin
          rep_done = 1'b1;
          r = model_decode(seg_in);
          if (r >= 0) begin
            exp_dv = 1; exp_digit = r; exp_blank = 0;
          end else if (r == -1) begin
            exp_blank = 1;
          end else begin
            exp_pe = 1;
            if (exp_cnt8 < 255) exp_cnt8++;
            if (exp_cnt2 < 3) exp_cnt2++;
          end
        end
      end
      exp_locked = rep_done ? 1 : 0;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("digit_out", d_digit, exp_digit);
      check("digit_valid", d_dv, exp_dv);
      check("pattern_err", d_pe, exp_pe);
      check("blank", d_blank, exp_blank);
      check("locked", d_locked, exp_locked);
      check("err_count", d_cnt, exp_cnt8);
      check("w2.digit_out", e_digit, exp_digit);
      check("w2.digit_valid", e_dv, exp_dv);
      check("w2.pattern_err", e_pe, exp_pe);
      check("w2.blank", e_blank, exp_blank);
      check("w2.locked", e_locked, exp_locked);
      check("w2.err_count", e_cnt, exp_cnt2);
    end
  end

  // Drive one cycle of inputs, then return just after the sampling edge.
  task automatic step(input logic r, input logic v, input logic [6:0] s);
    @(negedge clk);
    rst = r; seg_vld = v; seg_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, s);
  endtask

  initial begin
    logic [6:0] bad [5] = '{7'h01, 7'h11, 7'h22, 7'h33, 7'h44};
    rst = 1'b1; seg_vld = 1'b0; seg_in = 7'h00;
    step(1'b1, 1'b0, 7'h00);
    step(1'b1, 1'b1, 7'h24);
    chk_en = 1'b1;
    check("reset digit_out", d_digit, 0);
    check("reset locked", d_locked, 0);
    check("reset err_count", d_cnt, 0);
    check("reset digit_valid", d_dv, 0);

    // digit 2 after exactly four samples, then silence while held
    hold(7'h24, 3);
    check("dig2 early", d_dv, 0);
    hold(7'h24, 1);
    check("dig2 pulse", d_dv, 1);
    check("dig2 value", d_digit, 2);
    check("dig2 locked", d_locked, 1);
    hold(7'h24, 2);
    check("dig2 no repeat", d_dv, 0);

    // interrupted run: 3 never reported, 4 reported once
    hold(7'h30, 2);
    hold(7'h19, 3);
    check("dig4 early", d_dv, 0);
    check("dig4 settling", d_locked, 0);
    hold(7'h19, 1);
    check("dig4 pulse", d_dv, 1);
    check("dig4 value", d_digit, 4);

    // gaps in seg_vld do not break stability
    step(1'b0, 1'b1, 7'h12); step(1'b0, 1'b0, 7'h12);
    step(1'b0, 1'b1, 7'h12); step(1'b0, 1'b0, 7'h12);
    step(1'b0, 1'b1, 7'h12);
    check("dig5 early", d_dv, 0);
    step(1'b0, 1'b0, 7'h12);
    step(1'b0, 1'b1, 7'h12);
    check("dig5 pulse", d_dv, 1);
    check("dig5 value", d_digit, 5);

    // error, blank, then a digit clears blank
    hold(7'h55, 4);
    check("err pulse", d_pe, 1);
    check("err count", d_cnt, 1);
    check("err digit held", d_digit, 5);
    hold(7'h7F, 4);
    check("blank set", d_blank, 1);
    check("blank no pulse", d_dv, 0);
    check("blank digit held", d_digit, 5);
    hold(7'h00, 4);
    check("dig8 value", d_digit, 8);
    check("dig8 blank clr", d_blank, 0);

    // saturation of the narrow counter
    for (int i = 0; i < 5; i++) hold(bad[i], 4);
    check("w2 saturated", e_cnt, 3);
    check("w8 count", d_cnt, 6);

    // hex letter A
    hold(7'h08, 4);
`ifdef SEG_DECODE_HEX_ALPHA_EN
    check("hexA pulse", d_dv, 1);
    check("hexA value", d_digit, 10);
`else
    check("hexA error", d_pe, 1);
    check("hexA count", d_cnt, 7);
`endif

    // reset mid-settle discards the partial run
    hold(7'h79, 2);
    step(1'b1, 1'b1, 7'h79);
    check("midrst digit", d_digit, 0);
    check("midrst count", d_cnt, 0);
    hold(7'h79, 3);
    check("dig1 early", d_dv, 0);
    hold(7'h79, 1);
    check("dig1 pulse", d_dv, 1);
    check("dig1 value", d_digit, 1);

    step(1'b0, 1'b0, 7'h79);
    step(1'b0, 1'b0, 7'h79);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
